// File: rtl/montgomery_mult_pkg.sv
// Shared definitions for the radix-2 Montgomery multiplier: default widths and FSM encoding.
package montgomery_mult_pkg;

  localparam int unsigned N_DEFAULT  = 1024;
  localparam int unsigned AW_DEFAULT = 1027;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADD_B    = 4'd1,
    ST_WAIT_B   = 4'd2,
    ST_ADD_M    = 4'd3,
    ST_WAIT_M   = 4'd4,
    ST_SHIFT    = 4'd5,
    ST_SUB_M    = 4'd6,
    ST_WAIT_SUB = 4'd7,
    ST_FINISH   = 4'd8
  } state_e;

endpackage

// File: rtl/montgomery_mult_mpadder.sv
// Two-stage add/subtract unit: low half in the first cycle, high half plus carry in the second.
// result[AW] is the carry-out on add and the borrow on subtract.
module mpadder
  import montgomery_mult_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          subtract,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic [AW:0]   result,
  output logic          done
);

  localparam int unsigned LW  = AW / 2;
  localparam int unsigned UW  = AW - LW;
  localparam int unsigned LW1 = LW + 1;
  localparam int unsigned UW1 = UW + 1;

  logic [AW-1:0]  b_eff;
  logic [LW1-1:0] lo_sum;
  logic [UW1-1:0] hi_sum;

  logic           s1_q;
  logic [LW-1:0]  lo_q;
  logic           cy_q;
  logic [UW-1:0]  ahi_q;
  logic [UW-1:0]  bhi_q;
  logic           sub_q;
  logic [AW:0]    result_q;
  logic           done_q;

  // Subtraction is a + ~b + 1; the +1 enters as the low-half carry-in.
  assign b_eff  = subtract ? ~in_b : in_b;
  assign lo_sum = {1'b0, in_a[LW-1:0]} + {1'b0, b_eff[LW-1:0]} + LW1'(subtract);
  assign hi_sum = {1'b0, ahi_q} + {1'b0, bhi_q} + UW1'(cy_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_q  <= 1'b0;
      lo_q  <= '0;
      cy_q  <= 1'b0;
      ahi_q <= '0;
      bhi_q <= '0;
      sub_q <= 1'b0;
    end else begin
      s1_q <= start;
      if (start) begin
        lo_q  <= lo_sum[LW-1:0];
        cy_q  <= lo_sum[LW];
        ahi_q <= in_a[AW-1:LW];
        bhi_q <= b_eff[AW-1:LW];
        sub_q <= subtract;
      end
    end
  end

  // A set carry-out on subtract means no borrow, hence the inversion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= s1_q;
      if (s1_q) begin
        result_q <= {sub_q ? ~hi_sum[UW] : hi_sum[UW], hi_sum[UW-1:0], lo_q};
      end
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: rtl/montgomery_mult.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-N mod M, every add/subtract through one shared mpadder.
module montgomery_mult
  import montgomery_mult_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned AW = AW_DEFAULT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned CN = N + 2;
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    m_q, m_d;
  logic [CN-1:0]   c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    result_q, result_d;
  logic            done_q, done_d;
  logic            add_start_q, add_start_d;
  logic            add_sub_q, add_sub_d;
  logic [AW-1:0]   add_a_q, add_a_d;
  logic [AW-1:0]   add_b_q, add_b_d;

  logic [AW:0]     add_res;
  logic            add_done;
  logic            unused_add_par;

  mpadder #(.AW(AW)) u_adder (
    .clk      (clk),
    .resetn   (resetn),
    .start    (add_start_q),
    .subtract (add_sub_q),
    .in_a     (add_a_q),
    .in_b     (add_b_q),
    .result   (add_res),
    .done     (add_done)
  );

  // Only the low N+2 bits and the borrow bit of the adder result carry information.
  assign unused_add_par = ^add_res;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    done_d      = 1'b0;
    add_start_d = 1'b0;
    add_sub_d   = add_sub_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = in_a;
          b_d   = in_b;
          m_d   = in_m;
          c_d   = '0;
          cnt_d = '0;
          // C starts at zero, so with a_0 clear it is even and no M addition is needed.
          state_d = in_a[0] ? ST_ADD_B : ST_SHIFT;
        end
      end
      ST_ADD_B: begin
        add_start_d = 1'b1;
        add_sub_d   = 1'b0;
        add_a_d     = AW'(c_q);
        add_b_d     = AW'(b_q);
        state_d     = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (add_done) begin
          c_d     = add_res[CN-1:0];
          state_d = add_res[0] ? ST_ADD_M : ST_SHIFT;
        end
      end
      ST_ADD_M: begin
        add_start_d = 1'b1;
        add_sub_d   = 1'b0;
        add_a_d     = AW'(c_q);
        add_b_d     = AW'(m_q);
        state_d     = ST_WAIT_M;
      end
      ST_WAIT_M: begin
        if (add_done) begin
          c_d     = add_res[CN-1:0];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        c_d   = c_q >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_SUB_M;
        end else if (a_d[0]) begin
          state_d = ST_ADD_B;
        end else if (c_d[0]) begin
          state_d = ST_ADD_M;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SUB_M: begin
        add_start_d = 1'b1;
        add_sub_d   = 1'b1;
        add_a_d     = AW'(c_q);
        add_b_d     = AW'(m_q);
        state_d     = ST_WAIT_SUB;
      end
      ST_WAIT_SUB: begin
        if (add_done) begin
          // Borrow set means C < M already, so C is the reduced result.
          result_d = add_res[AW] ? c_q[N-1:0] : add_res[N-1:0];
          done_d   = 1'b1;
          state_d  = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      done_q      <= done_d;
      add_start_q <= add_start_d;
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed bench for montgomery_mult: a 1024-bit and an 8-bit instance sharing clock and reset.
module tb_montgomery_mult;
  import montgomery_mult_pkg::*;

  localparam int unsigned BOUND_W = 1024 * 9 + 5;
  localparam int unsigned BOUND_N = 8 * 9 + 5;

  logic          clk;
  logic          resetn;

  logic          start_w;
  logic [1023:0] a_w, b_w, m_w;
  logic [1023:0] result_w;
  logic          done_w;

  logic          start_n;
  logic [7:0]    a_n, b_n, m_n;
  logic [7:0]    result_n;
  logic          done_n;

  int total = 0;
  int bad   = 0;
  int done_cnt_w = 0;
  int done_cnt_n = 0;
  int addb_cnt_n = 0;

  logic [1023:0] m_all1;

  montgomery_mult #(.N(1024), .AW(1027)) dut_w (
    .clk(clk), .resetn(resetn), .start(start_w),
    .in_a(a_w), .in_b(b_w), .in_m(m_w),
    .result(result_w), .done(done_w)
  );

  montgomery_mult #(.N(8), .AW(11)) dut_n (
    .clk(clk), .resetn(resetn), .start(start_n),
    .in_a(a_n), .in_b(b_n), .in_m(m_n),
    .result(result_n), .done(done_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done_w === 1'b1) done_cnt_w <= done_cnt_w + 1;
    if (done_n === 1'b1) done_cnt_n <= done_cnt_n + 1;
    if (dut_n.state_q == ST_ADD_B) addb_cnt_n <= addb_cnt_n + 1;
  end

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed(lo128)=%0h expected(lo128)=%0h", tag, obs[127:0], want[127:0]);
    end
  endtask

  task automatic chk_le(input string tag, input int obs, input int lim);
    total++;
    assert (obs <= lim) else begin
      bad++;
      $error("FAIL %s observed=%0d expected<=%0d", tag, obs, lim);
    end
  endtask

  task automatic wait_done_n(output int cyc);
    cyc = 1;
    while (done_n !== 1'b1 && cyc < int'(BOUND_N) + 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_n(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] want, input string tag);
    int c0;
    int cyc;
    c0 = done_cnt_n;
    @(negedge clk);
    a_n = a; b_n = b; m_n = m; start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    a_n = 8'($urandom); b_n = 8'($urandom); m_n = 8'($urandom);
    wait_done_n(cyc);
    chk({tag, "_done"}, 1024'(done_n), 1024'(1));
    chk_le({tag, "_lat"}, cyc, int'(BOUND_N));
    chk(tag, 1024'(result_n), 1024'(want));
    repeat (3) @(negedge clk);
    chk({tag, "_ndone"}, 1024'(done_cnt_n - c0), 1024'(1));
  endtask

  task automatic run_w(input logic [1023:0] a, input logic [1023:0] b,
                       input logic [1023:0] want, input string tag);
    int c0;
    int cyc;
    c0 = done_cnt_w;
    @(negedge clk);
    a_w = a; b_w = b; m_w = m_all1; start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    a_w = '0; b_w = '1; m_w = 1024'(13);
    cyc = 1;
    while (done_w !== 1'b1 && cyc < int'(BOUND_W) + 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 1024'(done_w), 1024'(1));
    chk_le({tag, "_lat"}, cyc, int'(BOUND_W));
    chk(tag, result_w, want);
    repeat (3) @(negedge clk);
    chk({tag, "_ndone"}, 1024'(done_cnt_w - c0), 1024'(1));
  endtask

  initial begin
    int cyc;
    int c0;
    int b0;
    m_all1  = '1;
    resetn  = 1'b0;
    start_w = 1'b0; a_w = '0; b_w = '0; m_w = '0;
    start_n = 1'b0; a_n = '0; b_n = '0; m_n = '0;

    repeat (3) @(negedge clk);
    chk("rst_result_w", result_w, '0);
    chk("rst_done_w", 1024'(done_w), '0);
    chk("rst_result_n", 1024'(result_n), '0);
    chk("rst_done_n", 1024'(done_n), '0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Wide instance: with M = 2^1024-1, 2^-1024 mod M is 1, so results are plain products mod M.
    run_w(1024'(3), 1024'(5), 1024'(15), "w_3x5");
    run_w(m_all1 - 1024'(1), m_all1 - 1024'(1), 1024'(1), "w_m1sq");
    run_w(1024'(2), m_all1 - 1024'(1), m_all1 - 1024'(2), "w_2xm1");

    // Narrow instance, M=13: 2^-8 mod 13 = 3.
    run_n(8'd5, 8'd7, 8'd13, 8'd1, "n_5x7");
    b0 = addb_cnt_n;
    run_n(8'd0, 8'd7, 8'd13, 8'd0, "n_0x7");
    chk("n_0x7_no_addb", 1024'(addb_cnt_n - b0), '0);
    run_n(8'd1, 8'd1, 8'd13, 8'd3, "n_1x1");
    run_n(8'd12, 8'd1, 8'd13, 8'd10, "n_12x1");
    run_n(8'd12, 8'd12, 8'd13, 8'd3, "n_12x12");
    // M=255: 2^8 mod 255 = 1.
    run_n(8'd200, 8'd100, 8'd255, 8'd110, "n_200x100");
    run_n(8'd254, 8'd254, 8'd255, 8'd1, "n_254sq");

    // Starts during WAIT_M and during FINISH must be ignored.
    c0 = done_cnt_n;
    @(negedge clk);
    a_n = 8'd5; b_n = 8'd7; m_n = 8'd13; start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    cyc = 0;
    while (dut_n.state_q != ST_WAIT_M && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("ign_reach_waitm", 1024'(dut_n.state_q == ST_WAIT_M), 1024'(1));
    a_n = 8'd12; b_n = 8'd12; m_n = 8'd13; start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    wait_done_n(cyc);
    chk("ign_done", 1024'(done_n), 1024'(1));
    chk("ign_result", 1024'(result_n), 1024'(1));
    a_n = 8'd1; b_n = 8'd1; m_n = 8'd13; start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    repeat (200) @(negedge clk);
    chk("ign_ndone", 1024'(done_cnt_n - c0), 1024'(1));
    chk("ign_result_hold", 1024'(result_n), 1024'(1));

    // Reset in the middle of an operation aborts it.
    c0 = done_cnt_n;
    @(negedge clk);
    a_n = 8'd5; b_n = 8'd7; m_n = 8'd13; start_n = 1'b1;
    @(negedge clk);
    start_n = 1'b0;
    cyc = 0;
    while (dut_n.state_q != ST_WAIT_B && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_waitb", 1024'(dut_n.state_q == ST_WAIT_B), 1024'(1));
    resetn = 1'b0;
    #1;
    chk("rst_mid_done", 1024'(done_n), '0);
    chk("rst_mid_result", 1024'(result_n), '0);
    chk("rst_mid_idle", 1024'(dut_n.state_q == ST_IDLE), 1024'(1));
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_ndone", 1024'(done_cnt_n - c0), '0);
    run_n(8'd5, 8'd7, 8'd13, 8'd1, "n_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/montgomery_mult.md
MONTGOMERY_MULT -- requirements
Module: montgomery_mult

Interface
REQ-001 SHALL have parameter N, default 1024, operand/modulus width in bits.
REQ-002 SHALL have parameter AW, default 1027, adder input width; the adder result is AW+1 bits; N+2 <= AW SHALL hold.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request pulse; operands sampled on the same edge.
REQ-006 SHALL have port in_a  input  N  multiplier A; A < M.
REQ-007 SHALL have port in_b  input  N  multiplicand B; B < M.
REQ-008 SHALL have port in_m  input  N  modulus M; odd, M > 1.
REQ-009 SHALL have port result  output  N  A*B*2^-N mod M; valid from the done pulse until the next accepted start.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL compute radix-2 Montgomery product: C=0; for i=0..N-1: if a_i, C=C+B; if C odd, C=C+M; C=C>>1; finally if C>=M, C=C-M.
REQ-012 SHALL perform every addition/subtraction through the mpadder instance, inputs zero-extended to AW bits.
REQ-013 SHALL drive adder start for exactly one cycle per operation and capture the adder result only in the cycle its done is high.
REQ-014 SHALL register A, B and M on the start edge; later input changes SHALL have no effect on the running operation.
REQ-015 FSM states: IDLE, ADD_B, WAIT_B, ADD_M, WAIT_M, SHIFT, SUB_M, WAIT_SUB, FINISH.
REQ-016 IDLE->ADD_B on start if a_0=1, else ->SHIFT-decision path (ADD_M if C odd, else SHIFT).
REQ-017 ADD_B->WAIT_B unconditionally; WAIT_B on adder done: capture C, ->ADD_M if captured LSB=1 else ->SHIFT.
REQ-018 ADD_M->WAIT_M; WAIT_M on adder done: capture C, ->SHIFT.
REQ-019 SHIFT: C=C>>1, shift the A register right by one, increment the iteration counter; after iteration N-1 ->SUB_M, else ->ADD_B if next a_i=1, else ->ADD_M if C odd, else stay in SHIFT.
REQ-020 SUB_M issues C-M with subtract=1; WAIT_SUB on done: if adder result bit AW (borrow) is 0, result = low N bits of difference, else result = C; ->FINISH.
REQ-021 FINISH asserts done for one cycle, ->IDLE.
REQ-022 Iteration counter SHALL be ceil(log2(N+1)) bits and SHALL not wrap within an operation.
REQ-023 Intermediate C SHALL be held in N+2 bits; C < 2M is invariant after each SHIFT.
REQ-024 start outside IDLE SHALL be ignored; start coincident with FINISH SHALL be ignored.
REQ-025 Latency: variable, bounded by N*(2*(Ladd+2)+1) + Ladd + 3 cycles, where Ladd is the adder start-to-done latency.

Reset
REQ-026 resetn low SHALL asynchronously force: state IDLE, done 0, result 0, C 0, counter 0, adder start 0.
REQ-027 Reset mid-operation SHALL abort; the in-flight adder result SHALL be discarded and no done pulse issued.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the N/AW defaults.
REQ-029 The one sub-module SHALL be mpadder (clk, resetn, start, subtract, in_a, in_b, result, done), instantiated once.

Verification
REQ-030 N=1024, M=2^1024-1, A=3, B=5 -> result=15, one done pulse.
REQ-031 N=1024, M=2^1024-1, A=B=M-1 -> result=1.
REQ-032 N=8, M=13, A=5, B=7 -> result=1; A=0, B=7 -> result=0 with no ADD_B operations issued.
REQ-033 Start pulse during WAIT_M with different operands -> ignored; first result unchanged; exactly one done.
REQ-034 resetn low during WAIT_B -> done stays 0, result=0, FSM in IDLE; next start with N=8, M=13, A=5, B=7 -> result=1.
